hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage core. It generates the per-stage hold (EN) and clear (CLR) controls consumed by the F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding selects. It also tracks multi-cycle data-memory accesses with a small wait FSM and timeout counter. Pipeline registers hold when their EN input is 1 and clear synchronously when their CLR input is 1, so this block drives those inputs directly.

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: forwarding selects, branch flush, load-use stall
// and a wait FSM with timeout for multi-cycle data-memory accesses.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RS1_D,
    input  logic [4:0] RS2_D,
    input  logic [4:0] RS1_E,
    input  logic [4:0] RS2_E,
    input  logic [4:0] RD_E,
    input  logic [4:0] RD_M,
    input  logic [4:0] RD_W,
    input  logic       LOAD_E,
    input  logic       REG_WRITE_M,
    input  logic       REG_WRITE_W,
    input  logic       PC_SRC_E,
    input  logic       MEM_REQ_M,
    input  logic       MEM_ACK,
    output logic       STALL_F,
    output logic       STALL_D,
    output logic       STALL_E,
    output logic       STALL_M,
    output logic       FLUSH_D,
    output logic       FLUSH_E,
    output logic       FLUSH_W,
    output logic [1:0] FWD_A_E,
    output logic [1:0] FWD_B_E,
    output logic       MEM_ERR
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic {
        StRun     = 1'b0,
        StMemWait = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_stall;
    logic            mem_err;
    logic            mem_flush_w;
    logic            branch_flush;
    logic            load_use;

    // M-stage result is newer than W-stage, so it wins.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (REG_WRITE_M && (RD_M != 5'd0) && (RD_M == rs)) begin
            return 2'b10;
        end else if (REG_WRITE_W && (RD_W != 5'd0) && (RD_W == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_stall   = 1'b0;
        mem_err     = 1'b0;
        mem_flush_w = 1'b0;
        case (state_q)
            StRun: begin
                // An access acked in its first cycle never stalls.
                if (MEM_REQ_M && !MEM_ACK) begin
                    mem_stall   = 1'b1;
                    mem_flush_w = 1'b1;
                    state_d     = StMemWait;
                    cnt_d       = '0;
                end
            end
            StMemWait: begin
                if (MEM_ACK) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    mem_err     = 1'b1;
                    mem_flush_w = 1'b1;
                    state_d     = StRun;
                    cnt_d       = '0;
                end else begin
                    mem_stall   = 1'b1;
                    mem_flush_w = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        branch_flush = PC_SRC_E && !mem_stall;
        load_use     = LOAD_E && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D))
                       && !mem_stall && !PC_SRC_E;
    end

    always_comb begin
        STALL_F = 1'b0;
        STALL_D = 1'b0;
        STALL_E = 1'b0;
        STALL_M = 1'b0;
        FLUSH_D = 1'b0;
        FLUSH_E = 1'b0;
        FLUSH_W = 1'b0;
        FWD_A_E = 2'b00;
        FWD_B_E = 2'b00;
        MEM_ERR = 1'b0;
        if (!rst) begin
            STALL_F = mem_stall || load_use;
            STALL_D = mem_stall || load_use;
            STALL_E = mem_stall;
            STALL_M = mem_stall;
            FLUSH_D = branch_flush;
            FLUSH_E = branch_flush || load_use;
            FLUSH_W = mem_flush_w;
            FWD_A_E = fwd_sel(RS1_E);
            FWD_B_E = fwd_sel(RS2_E);
            MEM_ERR = mem_err;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven combinational vectors plus
// hand-written sequences for memory wait, timeout, priority and reset mid-wait.
module tb_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic       clk;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, reg_write_m, reg_write_w, pc_src_e, mem_req_m, mem_ack;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       mem_err;
    logic [11:0] got;

    int total;
    int bad;

    hazard_ctrl #(
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RS1_D      (rs1_d),
        .RS2_D      (rs2_d),
        .RS1_E      (rs1_e),
        .RS2_E      (rs2_e),
        .RD_E       (rd_e),
        .RD_M       (rd_m),
        .RD_W       (rd_w),
        .LOAD_E     (load_e),
        .REG_WRITE_M(reg_write_m),
        .REG_WRITE_W(reg_write_w),
        .PC_SRC_E   (pc_src_e),
        .MEM_REQ_M  (mem_req_m),
        .MEM_ACK    (mem_ack),
        .STALL_F    (stall_f),
        .STALL_D    (stall_d),
        .STALL_E    (stall_e),
        .STALL_M    (stall_m),
        .FLUSH_D    (flush_d),
        .FLUSH_E    (flush_e),
        .FLUSH_W    (flush_w),
        .FWD_A_E    (fwd_a_e),
        .FWD_B_E    (fwd_b_e),
        .MEM_ERR    (mem_err)
    );

    // Bit order: sf sd se sm | fd fe fw | fwd_a | fwd_b | err
    assign got = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                  fwd_a_e, fwd_b_e, mem_err};

    localparam logic [11:0] E_NONE  = 12'b0000_000_00_00_0;
    localparam logic [11:0] E_LU    = 12'b1100_010_00_00_0;
    localparam logic [11:0] E_BR    = 12'b0000_110_00_00_0;
    localparam logic [11:0] E_MEM   = 12'b1111_001_00_00_0;
    localparam logic [11:0] E_TOUT  = 12'b0000_001_00_00_1;

    typedef struct {
        logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic        lde, rwm, rww, pcs, req, ack;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic [4:0] rs1d, input logic [4:0] rs2d,
                                input logic [4:0] rs1e, input logic [4:0] rs2e,
                                input logic [4:0] rde, input logic [4:0] rdm,
                                input logic [4:0] rdw, input logic lde, input logic rwm,
                                input logic rww, input logic pcs, input logic req,
                                input logic ack, input logic [11:0] exp);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw;
        v.lde = lde; v.rwm = rwm; v.rww = rww; v.pcs = pcs; v.req = req; v.ack = ack;
        v.exp = exp;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rs1_d = v.rs1d; rs2_d = v.rs2d; rs1_e = v.rs1e; rs2_e = v.rs2e;
        rd_e = v.rde; rd_m = v.rdm; rd_w = v.rdw;
        load_e = v.lde; reg_write_m = v.rwm; reg_write_w = v.rww;
        pc_src_e = v.pcs; mem_req_m = v.req; mem_ack = v.ack;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b (sf sd se sm fd fe fw fa fb err)",
                     name, got, exp);
        end
    endtask

    task automatic clear_in();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE));
    endtask

    // Drive at negedge, sample 1 ns later, well away from the rising edge.
    task automatic cyc(input logic req, input logic ack, input string name,
                       input logic [11:0] exp);
        @(negedge clk);
        mem_req_m = req;
        mem_ack   = ack;
        #1;
        check(name, exp);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
        vecs[1]  = mk(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0, E_LU);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, E_NONE);
        vecs[3]  = mk(3, 9, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, E_LU);
        vecs[4]  = mk(5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE);
        vecs[5]  = mk(0, 0, 7, 0, 0, 7, 7, 0, 1, 1, 0, 0, 0, 12'b0000_000_10_00_0);
        vecs[6]  = mk(0, 0, 7, 0, 0, 7, 7, 0, 0, 1, 0, 0, 0, 12'b0000_000_01_00_0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, E_NONE);
        vecs[8]  = mk(0, 0, 3, 12, 0, 12, 12, 0, 0, 1, 0, 0, 0, 12'b0000_000_00_01_0);
        vecs[9]  = mk(0, 0, 3, 4, 0, 3, 4, 0, 1, 1, 0, 0, 0, 12'b0000_000_10_01_0);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, E_BR);
        vecs[11] = mk(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0, E_BR);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, E_NONE);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_NONE);

        // Reset: outputs forced low even with active inputs.
        apply(mk(5, 0, 7, 0, 5, 7, 0, 1, 1, 0, 1, 1, 0, E_NONE));
        rst = 1'b1;
        #1;
        check("reset_outputs", E_NONE);
        @(negedge clk);
        @(negedge clk);
        clear_in();
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Memory wait with ACK three cycles after the trigger.
        @(negedge clk);
        clear_in();
        cyc(1, 0, "wait_stall1", E_MEM);
        cyc(1, 0, "wait_stall2", E_MEM);
        cyc(1, 0, "wait_stall3", E_MEM);
        cyc(1, 1, "wait_ack", E_NONE);
        // Back-to-back: re-trigger right after release, then ACK after one cycle.
        cyc(1, 0, "b2b_trigger", E_MEM);
        cyc(1, 1, "b2b_ack", E_NONE);
        cyc(0, 0, "after_ack_run", E_NONE);

        // Timeout with TIMEOUT=4.
        for (int i = 0; i < TO; i++) cyc(1, 0, $sformatf("tout_stall%0d", i), E_MEM);
        cyc(1, 0, "tout_err", E_TOUT);
        cyc(0, 0, "tout_after", E_NONE);

        // Priority: branch beats load-use; memory stall beats both.
        @(negedge clk);
        apply(mk(5, 0, 0, 0, 5, 0, 0, 1, 0, 0, 1, 1, 0, E_NONE));
        #1;
        check("prio_mem", E_MEM);
        cyc(1, 1, "prio_ack_branch", E_BR);
        cyc(0, 0, "prio_branch_only", E_BR);
        @(negedge clk);
        clear_in();

        // Reset mid-wait with cnt=2.
        cyc(1, 0, "rst_trigger", E_MEM);
        cyc(1, 0, "rst_cnt0", E_MEM);
        cyc(1, 0, "rst_cnt1", E_MEM);
        cyc(1, 0, "rst_cnt2", E_MEM);
        #2;
        rst = 1'b1;
        #1;
        check("rst_midwait", E_NONE);
        @(negedge clk);
        mem_req_m = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_released", E_NONE);
        cyc(0, 0, "rst_idle", E_NONE);
        for (int i = 0; i < TO; i++) cyc(1, 0, $sformatf("rst_full%0d", i), E_MEM);
        cyc(1, 0, "rst_full_err", E_TOUT);
        cyc(0, 0, "rst_full_after", E_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
